trap_filter_param: RTL and testbench

TRAP_FILTER_PARAM -- requirements
Module: trap_filter_param

---
 rtl/filter_pkg.sv | 31 +++
 rtl/trap_delay_line.sv | 75 +++++++
 rtl/trap_filter_param.sv | 188 ++++++++++++++++++
 tb/tb_trap_filter_param.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/filter_pkg.sv
// Shared widths, reset-default configuration and the configuration record
// for the parameterised trapezoidal shaping filter.
package filter_pkg;

    localparam int unsigned SIZE_ADC_DATA    = 14;
    localparam int unsigned SIZE_FILTER_DATA = 16;
    localparam int unsigned SIZE_ACC_DATA    = 32;
    localparam int unsigned DEF_DEPTH_LOG2   = 6;
    localparam int unsigned DEF_M_W          = 10;
    localparam int unsigned SHIFT_W          = 5;

    localparam int unsigned DEF_K     = 5;
    localparam int unsigned DEF_L     = 9;
    localparam int unsigned DEF_M     = 0;
    localparam int unsigned DEF_SHIFT = 5;

    typedef struct packed {
        logic [DEF_DEPTH_LOG2-1:0] k;
        logic [DEF_DEPTH_LOG2-1:0] l;
        logic [DEF_M_W-1:0]        m;
        logic [SHIFT_W-1:0]        shift;
    } cfg_t;

    localparam cfg_t CFG_DEFAULT = '{
        k:     DEF_DEPTH_LOG2'(DEF_K),
        l:     DEF_DEPTH_LOG2'(DEF_L),
        m:     DEF_M_W'(DEF_M),
        shift: SHIFT_W'(DEF_SHIFT)
    };

endpackage

// File: rtl/trap_delay_line.sv
// Ring-buffer sample history with three read taps (k, l, k+l). A tap reads
// zero until enough samples have arrived, so the filter starts from zeros.
module trap_delay_line
    import filter_pkg::*;
#(
    parameter int unsigned DATA_W     = SIZE_ADC_DATA,
    parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  restart,
    input  logic [DEPTH_LOG2-1:0] dly_k,
    input  logic [DEPTH_LOG2-1:0] dly_l,
    output logic [DATA_W-1:0]     tap_k_c,
    output logic [DATA_W-1:0]     tap_l_c,
    output logic [DATA_W-1:0]     tap_kl_c
);

    localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
    localparam int unsigned FW       = DEPTH_LOG2 + 1;
    localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wp_q;
    logic [FW-1:0]         fill_q;
    logic [FW-1:0]         fill_eff_c;
    logic [FW-1:0]         fill_d;
    logic [FW-1:0]         dly_kl_c;
    logic [DEPTH_LOG2-1:0] idx_k_c;
    logic [DEPTH_LOG2-1:0] idx_l_c;
    logic [DEPTH_LOG2-1:0] idx_kl_c;

    // Sample storage; stale contents are masked by the fill counter.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wp_q] <= wr_data;
        end
    end

    // Write pointer wraps at the buffer depth; fill counter saturates there.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_q   <= '0;
            fill_q <= '0;
        end else begin
            if (wr_en) begin
                wp_q <= wp_q + DEPTH_LOG2'(1);
            end
            fill_q <= fill_d;
        end
    end

    // A restart makes the current sample the first one of a fresh history.
    always_comb begin
        fill_eff_c = restart ? '0 : fill_q;
        fill_d     = fill_eff_c;
        if (wr_en && (fill_eff_c != FILL_MAX)) begin
            fill_d = fill_eff_c + FW'(1);
        end
    end

    // Tap reads relative to the slot the current sample is about to occupy.
    always_comb begin
        dly_kl_c = FW'(dly_k) + FW'(dly_l);
        idx_k_c  = wp_q - dly_k;
        idx_l_c  = wp_q - dly_l;
        idx_kl_c = wp_q - dly_kl_c[DEPTH_LOG2-1:0];
        tap_k_c  = (fill_eff_c < FW'(dly_k)) ? '0 : mem[idx_k_c];
        tap_l_c  = (fill_eff_c < FW'(dly_l)) ? '0 : mem[idx_l_c];
        tap_kl_c = (fill_eff_c < dly_kl_c)   ? '0 : mem[idx_kl_c];
    end

endmodule

// File: rtl/trap_filter_param.sv
// Trapezoidal shaping filter with pole-zero correction, runtime-loadable
// k/l/M/shift, saturating output and a four-register pipeline.
module trap_filter_param
    import filter_pkg::*;
#(
    parameter int unsigned ADC_W      = SIZE_ADC_DATA,
    parameter int unsigned OUT_W      = SIZE_FILTER_DATA,
    parameter int unsigned ACC_W      = SIZE_ACC_DATA,
    parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int unsigned M_W        = DEF_M_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADC_W-1:0]        in_data,
    input  logic                    in_valid,
    input  logic [DEPTH_LOG2-1:0]   cfg_k,
    input  logic [DEPTH_LOG2-1:0]   cfg_l,
    input  logic [M_W-1:0]          cfg_m,
    input  logic [SHIFT_W-1:0]      cfg_shift,
    input  logic                    cfg_load,
    output logic                    cfg_err,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    output logic                    ovf
);

    localparam int unsigned DW    = ADC_W + 2;
    localparam int unsigned KLW   = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned HI_W  = ACC_W - OUT_W + 1;
    localparam logic [KLW-1:0] KL_MAX = KLW'(DEPTH - 1);

    logic [DEPTH_LOG2-1:0] k_q;
    logic [DEPTH_LOG2-1:0] l_q;
    logic [M_W-1:0]        m_q;
    logic [SHIFT_W-1:0]    shift_q;

    logic [KLW-1:0]        kl_sum_c;
    logic                  cfg_ok_c;
    logic                  load_ok_c;
    logic [DEPTH_LOG2-1:0] k_eff_c;
    logic [DEPTH_LOG2-1:0] l_eff_c;

    logic [ADC_W-1:0]      tap_k_c;
    logic [ADC_W-1:0]      tap_l_c;
    logic [ADC_W-1:0]      tap_kl_c;

    logic signed [DW-1:0]    d_c;
    logic signed [DW-1:0]    d_q;
    logic                    v1_q;
    logic                    v2_q;
    logic                    v3_q;
    logic signed [ACC_W-1:0] p_q;
    logic signed [ACC_W-1:0] r_q;
    logic signed [ACC_W-1:0] s_q;
    logic signed [ACC_W-1:0] d_ext_c;
    logic signed [ACC_W-1:0] m_ext_c;
    logic signed [ACC_W-1:0] p_next_c;
    logic signed [ACC_W-1:0] r_next_c;
    logic signed [ACC_W-1:0] shifted_c;
    logic [HI_W-1:0]         hi_c;
    logic                    sat_c;
    logic signed [OUT_W-1:0] res_c;

    // Legality of the presented config and the taps the current sample uses.
    always_comb begin
        kl_sum_c  = KLW'(cfg_k) + KLW'(cfg_l);
        cfg_ok_c  = (cfg_k != '0) && (cfg_k <= cfg_l) && (kl_sum_c <= KL_MAX);
        load_ok_c = cfg_load && cfg_ok_c;
        k_eff_c   = load_ok_c ? cfg_k : k_q;
        l_eff_c   = load_ok_c ? cfg_l : l_q;
    end

    trap_delay_line #(
        .DATA_W     (ADC_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_dly (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (in_valid),
        .wr_data  (in_data),
        .restart  (load_ok_c),
        .dly_k    (k_eff_c),
        .dly_l    (l_eff_c),
        .tap_k_c  (tap_k_c),
        .tap_l_c  (tap_l_c),
        .tap_kl_c (tap_kl_c)
    );

    // Active configuration and sticky rejection flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_q     <= DEPTH_LOG2'(CFG_DEFAULT.k);
            l_q     <= DEPTH_LOG2'(CFG_DEFAULT.l);
            m_q     <= M_W'(CFG_DEFAULT.m);
            shift_q <= SHIFT_W'(CFG_DEFAULT.shift);
            cfg_err <= 1'b0;
        end else if (cfg_load) begin
            cfg_err <= !cfg_ok_c;
            if (cfg_ok_c) begin
                k_q     <= cfg_k;
                l_q     <= cfg_l;
                m_q     <= cfg_m;
                shift_q <= cfg_shift;
            end
        end
    end

    // Datapath arithmetic: difference, pole-zero term, output shift and clamp.
    always_comb begin
        d_c       = DW'(in_data) - DW'(tap_k_c) - DW'(tap_l_c) + DW'(tap_kl_c);
        d_ext_c   = ACC_W'(d_q);
        m_ext_c   = ACC_W'({1'b0, m_q});
        p_next_c  = p_q + d_ext_c;
        r_next_c  = p_next_c + (d_ext_c * m_ext_c);
        shifted_c = s_q >>> shift_q;
        hi_c      = shifted_c[ACC_W-1:OUT_W-1];
        sat_c     = !((&hi_c) || !(|hi_c));
        res_c     = shifted_c[OUT_W-1:0];
        if (sat_c) begin
            res_c = shifted_c[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                       : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

    // Stage 1: difference of current sample and the three taps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_q <= 1'b0;
            d_q  <= '0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                d_q <= d_c;
            end
        end
    end

    // Stage 2: p accumulator and the pole-zero corrected r.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v2_q <= 1'b0;
            p_q  <= '0;
            r_q  <= '0;
        end else begin
            v2_q <= v1_q && !load_ok_c;
            if (load_ok_c) begin
                p_q <= '0;
            end else if (v1_q) begin
                p_q <= p_next_c;
                r_q <= r_next_c;
            end
        end
    end

    // Stage 3: s accumulator.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v3_q <= 1'b0;
            s_q  <= '0;
        end else begin
            v3_q <= v2_q && !load_ok_c;
            if (load_ok_c) begin
                s_q <= '0;
            end else if (v2_q) begin
                s_q <= s_q + r_q;
            end
        end
    end

    // Stage 4: shifted, saturated output and sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= v3_q && !load_ok_c;
            if (v3_q && !load_ok_c) begin
                out_data <= res_c;
                if (sat_c) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_trap_filter_param.sv
// Directed bench for trap_filter_param: a direct-form reference model pushes
// expected outputs (with due cycle) into a scoreboard popped by a monitor.
module tb_trap_filter_param;

    localparam int unsigned ADC_W      = 14;
    localparam int unsigned OUT_W      = 16;
    localparam int unsigned ACC_W      = 32;
    localparam int unsigned DEPTH_LOG2 = 6;
    localparam int unsigned M_W        = 10;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [ADC_W-1:0]        in_data;
    logic                    in_valid;
    logic [DEPTH_LOG2-1:0]   cfg_k;
    logic [DEPTH_LOG2-1:0]   cfg_l;
    logic [M_W-1:0]          cfg_m;
    logic [4:0]              cfg_shift;
    logic                    cfg_load;
    logic                    cfg_err;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_valid;
    logic                    ovf;

    always #5 clk = ~clk;

    trap_filter_param #(
        .ADC_W      (ADC_W),
        .OUT_W      (OUT_W),
        .ACC_W      (ACC_W),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .M_W        (M_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .cfg_k     (cfg_k),
        .cfg_l     (cfg_l),
        .cfg_m     (cfg_m),
        .cfg_shift (cfg_shift),
        .cfg_load  (cfg_load),
        .cfg_err   (cfg_err),
        .out_data  (out_data),
        .out_valid (out_valid),
        .ovf       (ovf)
    );

    typedef struct {
        int   cyc;
        int   val;
        logic ovf;
    } exp_t;

    exp_t sb[$];
    int   hist[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   p_m, s_m, mk, ml, mm, msh;
    logic ovf_m, err_m;
    logic mon_exp_v;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int tap(input int dly);
        if (hist.size() > dly) return hist[hist.size() - 1 - dly];
        return 0;
    endfunction

    task automatic model_reset();
        mk = 5; ml = 9; mm = 0; msh = 5;
        p_m = 0; s_m = 0;
        ovf_m = 1'b0; err_m = 1'b0;
        hist.delete();
        sb.delete();
    endtask

    task automatic model_sample(input int x);
        int d, r, y;
        hist.push_back(x);
        d = tap(0) - tap(mk) - tap(ml) + tap(mk + ml);
        p_m = p_m + d;
        r = p_m + mm * d;
        s_m = s_m + r;
        y = s_m >>> msh;
        if (y > 32767) begin
            y = 32767;
            ovf_m = 1'b1;
        end else if (y < -32768) begin
            y = -32768;
            ovf_m = 1'b1;
        end
        sb.push_back('{cyc: cyc + 4, val: y, ovf: ovf_m});
    endtask

    task automatic model_cfg(input int k, input int l, input int m, input int sh);
        if (k >= 1 && k <= l && (k + l) <= 63) begin
            mk = k; ml = l; mm = m; msh = sh;
            p_m = 0; s_m = 0;
            err_m = 1'b0;
            hist.delete();
            while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
        end else begin
            err_m = 1'b1;
        end
    endtask

    task automatic drive(input logic v, input int x);
        @(posedge clk); #1;
        cfg_load = 1'b0;
        in_valid = v;
        in_data  = ADC_W'(x);
        if (v) model_sample(x);
    endtask

    task automatic load(input int k, input int l, input int m, input int sh,
                        input logic v, input int x);
        @(posedge clk); #1;
        cfg_k     = DEPTH_LOG2'(k);
        cfg_l     = DEPTH_LOG2'(l);
        cfg_m     = M_W'(m);
        cfg_shift = 5'(sh);
        cfg_load  = 1'b1;
        in_valid  = v;
        in_data   = ADC_W'(x);
        model_cfg(k, l, m, sh);
        if (v) model_sample(x);
    endtask

    // Output monitor: valid must appear exactly when the scoreboard head is due.
    always @(negedge clk) begin
        mon_exp_v = (sb.size() > 0) && (sb[0].cyc == cyc);
        chk("out_valid", 32'(out_valid), 32'(mon_exp_v));
        if (mon_exp_v) begin
            chk("out_data", out_data, sb[0].val);
            chk("ovf", 32'(ovf), 32'(sb[0].ovf));
            void'(sb.pop_front());
        end
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_data = '0; cfg_load = 1'b0;
        cfg_k = '0; cfg_l = '0; cfg_m = '0; cfg_shift = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_cfg_err", 32'(cfg_err), 0);
        reset = 1'b1;

        // Step response, k=2 l=5 M=0 shift=0.
        load(2, 5, 0, 0, 1'b0, 0);
        drive(1'b1, 0);
        chk("cfg_err_legal", 32'(cfg_err), 32'(err_m));
        for (int i = 0; i < 9; i++) drive(1'b1, 0);
        for (int i = 0; i < 14; i++) drive(1'b1, 100);
        for (int i = 0; i < 6; i++) drive(1'b0, 0);

        // Same step with in_valid toggling.
        load(2, 5, 0, 0, 1'b0, 0);
        for (int i = 0; i < 10; i++) begin drive(1'b1, 0); drive(1'b0, 0); end
        for (int i = 0; i < 14; i++) begin drive(1'b1, 100); drive(1'b0, 0); end
        for (int i = 0; i < 6; i++) drive(1'b0, 0);

        // Pole-zero term and shift with random data and gaps; load with sample.
        load(3, 6, 37, 2, 1'b1, 1234);
        for (int i = 0; i < 40; i++)
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 16383)));

        // Illegal configs mid-stream: rejected, stream undisturbed.
        load(40, 40, 5, 1, 1'b1, 500);
        drive(1'b1, 700);
        chk("cfg_err_big", 32'(cfg_err), 32'(err_m));
        for (int i = 0; i < 10; i++) drive(1'b1, int'($urandom_range(0, 16383)));
        load(7, 3, 1, 1, 1'b0, 0);
        drive(1'b1, 900);
        chk("cfg_err_k_gt_l", 32'(cfg_err), 32'(err_m));
        load(0, 4, 1, 1, 1'b1, 50);
        drive(1'b1, 60);
        chk("cfg_err_k_zero", 32'(cfg_err), 32'(err_m));
        for (int i = 0; i < 8; i++) drive(1'b1, int'($urandom_range(0, 16383)));

        // Legal reload clears the error and restarts from zero mid-stream.
        load(4, 8, 3, 3, 1'b0, 0);
        drive(1'b1, 300);
        chk("cfg_err_clear", 32'(cfg_err), 32'(err_m));
        for (int i = 0; i < 20; i++) drive(1'b1, int'($urandom_range(0, 16383)));
        load(6, 10, 1, 4, 1'b0, 0);
        for (int i = 0; i < 20; i++) drive(1'b1, int'($urandom_range(0, 16383)));
        load(2, 5, 0, 0, 1'b1, 100);
        for (int i = 0; i < 12; i++) drive(1'b1, 100);
        for (int i = 0; i < 6; i++) drive(1'b0, 0);

        // Output saturation.
        load(31, 32, 0, 0, 1'b0, 0);
        for (int i = 0; i < 80; i++) drive(1'b1, 16383);
        for (int i = 0; i < 6; i++) drive(1'b0, 0);
        chk("ovf_sticky", 32'(ovf), 1);

        // One-cycle reset mid-stream, then default-config step.
        for (int i = 0; i < 8; i++) drive(1'b1, 100);
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0; cfg_load = 1'b0;
        model_reset();
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_ovf", 32'(ovf), 0);
        chk("mid_rst_cfg_err", 32'(cfg_err), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) drive(1'b1, 0);
        for (int i = 0; i < 20; i++) drive(1'b1, 100);

        for (int i = 0; i < 20 && sb.size() > 0; i++) drive(1'b0, 0);
        chk("drain_pending", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
